// File: rtl/riscv_pkg.sv
// riscv_pkg: fetch-stage state encoding, NOP word and opcode constants shared with the Controller
package riscv_pkg;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        FAULT
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    function automatic logic word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_next.sv
// pc_next: sequential-PC adder, PCSrc mux and word-alignment check for the next fetch address
module pc_next
    import riscv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        next_misaligned
);

    // pc + 4 wraps modulo 2^32; only a taken target can be misaligned
    always_comb begin
        pc_plus4        = pc + 32'd4;
        next_pc         = pc_src ? pc_target : pc_plus4;
        next_misaligned = !word_aligned(next_pc);
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner and req/ack instruction fetch that holds each word until retire
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        retire,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic        misaligned
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  next_pc;
    logic         next_misaligned;

    pc_next u_pc_next (
        .pc              (pc_q),
        .pc_src          (pc_src),
        .pc_target       (pc_target),
        .pc_plus4        (pc_plus4),
        .next_pc         (next_pc),
        .next_misaligned (next_misaligned)
    );

    // FETCH waits for ack, HOLD waits for retire, FAULT is left only by reset
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            FETCH: if (imem_ack) begin
                instr_d = imem_rdata;
                state_d = HOLD;
            end
            HOLD: if (retire) begin
                state_d = next_misaligned ? FAULT : FETCH;
                pc_d    = next_misaligned ? pc_q : next_pc;
            end
            default: ;
        endcase
    end

    // state, pc and instruction registers; reset beats a concurrent ack or retire
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imem_req    = (state_q == FETCH) && !reset;
    assign imem_addr   = pc_q;
    assign instr_valid = state_q == HOLD;
    assign misaligned  = state_q == FAULT;
    assign instr       = instr_q;
    assign op          = instr_q[6:0];
    assign funct3      = instr_q[14:12];
    assign funct7b5    = instr_q[30];
    assign pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus with fetch-address and instruction scoreboards for instr_fetch
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset, imem_req, imem_ack, instr_valid, funct7b5;
    logic        retire, pc_src, misaligned;
    logic [31:0] imem_addr, imem_rdata, instr, pc, pc_plus4, pc_target;
    logic [6:0]  op;
    logic [2:0]  funct3;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_instr[$];

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h100)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .retire      (retire),
        .pc_src      (pc_src),
        .pc_target   (pc_target),
        .misaligned  (misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // drive one cycle's inputs at the falling edge, then settle before checking
    task automatic cyc(input logic r, input logic rt, input logic ps, input logic [31:0] tg,
                       input logic ak, input logic [31:0] rd);
        @(negedge clk);
        reset = r; retire = rt; pc_src = ps; pc_target = tg; imem_ack = ak; imem_rdata = rd;
        #1;
    endtask

    task automatic pop_addr();
        if (exp_addr.size() == 0) begin
            checks++; failures++;
            $error("FAIL sb_addr queue empty got=%h", imem_addr);
        end else begin
            chk("sb_addr_req", {31'd0, imem_req}, 32'd1);
            chk("sb_addr", imem_addr, exp_addr.pop_front());
        end
    endtask

    task automatic pop_instr();
        if (exp_instr.size() == 0) begin
            checks++; failures++;
            $error("FAIL sb_instr queue empty got=%h", instr);
        end else begin
            chk("sb_valid", {31'd0, instr_valid}, 32'd1);
            chk("sb_instr", instr, exp_instr.pop_front());
        end
    endtask

    initial begin
        reset = 1; retire = 0; pc_src = 0; pc_target = 0; imem_ack = 0; imem_rdata = 0;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_mis", {31'd0, misaligned}, 32'd0);
        chk("rst_instr", instr, 32'h13);
        chk("rst_pc", pc, 32'h100);
        // reset release with a zero-wait ack of lw
        exp_addr.push_back(32'h100);
        cyc(0, 0, 0, 0, 1, 32'h0000_2083);
        exp_instr.push_back(32'h0000_2083);
        pop_addr();
        chk("rel_op", {25'd0, op}, 32'h13);
        chk("rel_valid", {31'd0, instr_valid}, 32'd0);
        // HOLD: retire sequentially in the first cycle
        exp_addr.push_back(32'h104);
        cyc(0, 1, 0, 0, 0, 0);
        pop_instr();
        chk("lw_op", {25'd0, op}, 32'h03);
        chk("lw_f3", {29'd0, funct3}, 32'd2);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_pc4", pc_plus4, 32'h104);
        // three wait states at 0x104
        cyc(0, 0, 0, 0, 0, 0);
        pop_addr();
        chk("ws_valid", {31'd0, instr_valid}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0, 0, 32'hDEAD_BEEF);
            chk("ws_req", {31'd0, imem_req}, 32'd1);
            chk("ws_addr", imem_addr, 32'h104);
            chk("ws_valid", {31'd0, instr_valid}, 32'd0);
        end
        cyc(0, 0, 0, 0, 1, 32'h40B5_0533);
        exp_instr.push_back(32'h40B5_0533);
        chk("ws4_addr", imem_addr, 32'h104);
        exp_addr.push_back(32'h108);
        cyc(0, 1, 0, 0, 0, 0);
        pop_instr();
        chk("sub_f7b5", {31'd0, funct7b5}, 32'd1);
        chk("sub_op", {25'd0, op}, 32'h33);
        // taken branch from 0x108 to 0x0F0
        cyc(0, 0, 0, 0, 1, 32'h0020_8463);
        exp_instr.push_back(32'h0020_8463);
        pop_addr();
        exp_addr.push_back(32'h0F0);
        cyc(0, 1, 1, 32'h0F0, 0, 0);
        pop_instr();
        chk("br_pc", pc, 32'h108);
        cyc(0, 0, 0, 0, 1, 32'h0010_0093);
        exp_instr.push_back(32'h0010_0093);
        pop_addr();
        chk("br_pc4", pc_plus4, 32'h0F4);
        // misaligned taken target faults
        cyc(0, 1, 1, 32'h0F2, 0, 0);
        pop_instr();
        chk("mis_pre_pc", pc, 32'h0F0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("mis_flag", {31'd0, misaligned}, 32'd1);
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        chk("mis_pc", pc, 32'h0F0);
        chk("mis_valid", {31'd0, instr_valid}, 32'd0);
        cyc(0, 1, 0, 0, 1, 32'h0000_2083);
        cyc(0, 0, 0, 0, 0, 0);
        chk("flt_mis", {31'd0, misaligned}, 32'd1);
        chk("flt_req", {31'd0, imem_req}, 32'd0);
        chk("flt_pc", pc, 32'h0F0);
        chk("flt_instr", instr, 32'h0010_0093);
        chk("flt_valid", {31'd0, instr_valid}, 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("clr_mis", {31'd0, misaligned}, 32'd0);
        chk("clr_pc", pc, 32'h100);
        // pc_plus4 wrap from 0xFFFF_FFFC
        exp_addr.push_back(32'h100);
        cyc(0, 0, 0, 0, 1, 32'h0000_006F);
        exp_instr.push_back(32'h0000_006F);
        pop_addr();
        exp_addr.push_back(32'hFFFF_FFFC);
        cyc(0, 1, 1, 32'hFFFF_FFFC, 0, 0);
        pop_instr();
        cyc(0, 0, 0, 0, 1, 32'h0000_0013);
        exp_instr.push_back(32'h0000_0013);
        pop_addr();
        chk("wrap_pc4", pc_plus4, 32'h0);
        exp_addr.push_back(32'h0);
        cyc(0, 1, 0, 0, 0, 0);
        pop_instr();
        cyc(0, 0, 0, 0, 0, 0);
        pop_addr();
        chk("wrap_mis", {31'd0, misaligned}, 32'd0);
        chk("wrap_pc", pc, 32'h0);
        // reset together with retire
        cyc(0, 0, 0, 0, 1, 32'h0000_2083);
        cyc(1, 1, 1, 32'h200, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("rr_pc", pc, 32'h100);
        chk("rr_instr", instr, 32'h13);
        chk("rr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rr_req", {31'd0, imem_req}, 32'd0);
        // reset together with ack in FETCH
        cyc(0, 0, 0, 0, 0, 0);
        chk("ra_req", {31'd0, imem_req}, 32'd1);
        cyc(1, 0, 0, 0, 1, 32'h0000_2083);
        cyc(0, 0, 0, 0, 0, 0);
        chk("ra_instr", instr, 32'h13);
        chk("ra_op", {25'd0, op}, 32'h13);
        chk("ra_valid", {31'd0, instr_valid}, 32'd0);
        chk("ra_req2", {31'd0, imem_req}, 32'd1);
        chk("ra_addr", imem_addr, 32'h100);
        chk("sb_drain", exp_addr.size() + exp_instr.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
